// File: rtl/qa_drv_hc_wr_sched_if.sv
// Write-request bus between the host-channel requesters, the scheduler and the c1 Tx stage.
// The slave view belongs to the scheduler; the master view drives requests and FIU feedback.
interface qa_drv_hc_wr_sched_if #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = 42,
  parameter int unsigned DATA_W = 512
);
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0][DATA_W-1:0] req_data;
  logic [N_REQ-1:0]             req_grant;
  logic                         tx_valid;
  logic [ADDR_W-1:0]            tx_addr;
  logic [DATA_W-1:0]            tx_data;
  logic                         tx_almfull;
  logic                         wr_rsp_valid;

  modport slave (
    input  req_valid, req_addr, req_data, tx_almfull, wr_rsp_valid,
    output req_grant, tx_valid, tx_addr, tx_data
  );

  modport master (
    output req_valid, req_addr, req_data, tx_almfull, wr_rsp_valid,
    input  req_grant, tx_valid, tx_addr, tx_data
  );
endinterface

// File: rtl/qa_drv_hc_wr_sched.sv
// Round-robin scheduler sharing the c1 Tx write channel among host-channel requesters,
// with almost-full backpressure, an outstanding-write credit limit and a drain sequence.
module qa_drv_hc_wr_sched #(
  parameter int unsigned N_REQ           = 3,
  parameter int unsigned MAX_OUTSTANDING = 32,
  parameter int unsigned ADDR_W          = 42,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  qa_drv_hc_wr_sched_if.slave       bus,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      rsp_underflow
);

  localparam int unsigned LAST_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned DATA_W = 512;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e              state_q;
  logic                drain_done_q;
  logic                almfull_q;
  logic [LAST_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                underflow_q, underflow_d;
  logic                tx_valid_q, tx_valid_d;
  logic [ADDR_W-1:0]   tx_addr_q, tx_addr_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;

  logic                grant_ok_c;
  logic                win_found_c;
  logic [LAST_W-1:0]   win_c;
  logic [N_REQ-1:0]    grant_c;
  logic                grant_c_any;

  // Round-robin search starting just after the last winner; only registered state gates it
  always_comb begin
    int unsigned idx;
    idx         = 0;
    win_found_c = 1'b0;
    win_c       = last_q;
    grant_c     = '0;
    grant_ok_c  = (state_q == ST_RUN) && !almfull_q &&
                  (cnt_q < CNT_W'(MAX_OUTSTANDING));
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_q) + k) % N_REQ;
      if (!win_found_c && bus.req_valid[LAST_W'(idx)]) begin
        win_found_c = 1'b1;
        win_c       = LAST_W'(idx);
      end
    end
    if (grant_ok_c && win_found_c) begin
      grant_c[win_c] = 1'b1;
    end
  end

  assign grant_c_any = |grant_c;

  // Next-state for the tx register, the pointer and the credit counter
  always_comb begin
    tx_valid_d  = 1'b0;
    tx_addr_d   = tx_addr_q;
    tx_data_d   = tx_data_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    underflow_d = underflow_q;
    if (grant_c_any) begin
      tx_valid_d = bus.req_valid[win_c];
      tx_addr_d  = bus.req_addr[win_c];
      tx_data_d  = bus.req_data[win_c];
      last_d     = win_c;
    end
    // A response with no credit in use is a protocol error; the counter pins at zero
    if (bus.wr_rsp_valid && (cnt_q == '0)) begin
      underflow_d = 1'b1;
    end
    case ({grant_c_any, bus.wr_rsp_valid})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
      almfull_q    <= 1'b1;
      last_q       <= LAST_W'(N_REQ - 1);
      cnt_q        <= '0;
      underflow_q  <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_addr_q    <= '0;
      tx_data_q    <= '0;
    end else begin
      almfull_q   <= bus.tx_almfull;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
      tx_valid_q  <= tx_valid_d;
      tx_addr_q   <= tx_addr_d;
      tx_data_q   <= tx_data_d;
      // drain_done tracks the DONE state on the same edge
      case (state_q)
        ST_RUN: begin
          if (drain_req) begin
            state_q      <= ST_DRAIN;
            drain_done_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!drain_req) begin
            state_q      <= ST_RUN;
            drain_done_q <= 1'b0;
          end else if ((cnt_q == '0) && !tx_valid_q) begin
            state_q      <= ST_DONE;
            drain_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!drain_req) begin
            state_q      <= ST_RUN;
            drain_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_RUN;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_grant  = grant_c;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_addr    = tx_addr_q;
  assign bus.tx_data    = tx_data_q;
  assign drain_done     = drain_done_q;
  assign outstanding    = cnt_q;
  assign rsp_underflow  = underflow_q;

endmodule

// File: tb/tb_qa_drv_hc_wr_sched.sv
// Scoreboard bench for the write scheduler: stimulus queues expected tx writes,
// a negedge monitor pops and compares whenever tx_valid is presented.
module tb_qa_drv_hc_wr_sched;
  localparam int unsigned N_REQ   = 3;
  localparam int unsigned MAX_OUT = 32;
  localparam int unsigned ADDR_W  = 42;
  localparam int unsigned CNT_W   = 6;

  typedef logic [ADDR_W-1:0] addr_t;

  logic clk = 1'b0;
  logic reset_n;
  logic drain_req;
  logic drain_done;
  logic rsp_underflow;
  logic [CNT_W-1:0] outstanding;

  always #5 clk = ~clk;

  qa_drv_hc_wr_sched_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W)) bus ();

  qa_drv_hc_wr_sched #(
    .N_REQ(N_REQ), .MAX_OUTSTANDING(MAX_OUT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .drain_req(drain_req),
    .drain_done(drain_done), .outstanding(outstanding), .rsp_underflow(rsp_underflow)
  );

  int n_vec = 0;
  int n_err = 0;
  addr_t src_q [N_REQ][$];
  addr_t exp_q [$];
  int    tx_cyc_q [$];
  int    gnt_hist [$];
  logic [N_REQ-1:0] en;
  logic [N_REQ-1:0] gs;
  logic  txv_s;
  int    exp_out = 0;
  int    cyc = 0;
  int    n_g = 0;
  int    g_first = -1;
  int    g_last = -1;

  function automatic logic [511:0] line_data(addr_t a);
    return {8{64'(a) ^ 64'hC3A5_0000_0000_0000}};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N_REQ; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        bus.req_valid[i] = 1'b1;
        bus.req_addr[i]  = src_q[i][0];
        bus.req_data[i]  = line_data(src_q[i][0]);
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_addr[i]  = '0;
        bus.req_data[i]  = '0;
      end
    end
  endtask

  // One clock: sample grant mid-cycle, cross the edge, consume granted lines, check credits
  task automatic tick();
    #1;
    gs    = bus.req_grant;
    txv_s = bus.tx_valid;
    chk("grant_onehot", 64'($countones(gs) <= 1), 1);
    chk("grant_without_req", 64'(gs & ~bus.req_valid), 0);
    for (int i = 0; i < N_REQ; i++) if (gs[i]) gnt_hist.push_back(i);
    if (gs != 0) begin
      n_g++;
      if (g_first < 0) g_first = cyc;
      g_last = cyc;
    end
    if ((gs != 0) && !bus.wr_rsp_valid) exp_out++;
    else if ((gs == 0) && bus.wr_rsp_valid && exp_out > 0) exp_out--;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N_REQ; i++)
      if (gs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive_reqs();
    chk("outstanding", 64'(outstanding), 64'(exp_out));
  endtask

  task automatic clr_stats();
    n_g = 0; g_first = -1; g_last = -1;
    gnt_hist.delete();
    tx_cyc_q.delete();
  endtask

  task automatic ret_credits();
    en = '0;
    drive_reqs();
    bus.wr_rsp_valid = 1'b1;
    for (int t = 0; t < 64 && exp_out > 0; t++) tick();
    bus.wr_rsp_valid = 1'b0;
    chk("credits_returned", 64'(outstanding), 0);
  endtask

  // Asynchronous reset a few ns after an edge; outputs must clear before the next edge
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_tx_valid", 64'(bus.tx_valid), 0);
    chk("rst_tx_addr", 64'(bus.tx_addr), 0);
    chk("rst_tx_data", 64'(bus.tx_data == '0), 1);
    chk("rst_outstanding", 64'(outstanding), 0);
    chk("rst_underflow", 64'(rsp_underflow), 0);
    chk("rst_drain_done", 64'(drain_done), 0);
    chk("rst_grant", 64'(bus.req_grant), 0);
    for (int i = 0; i < N_REQ; i++) src_q[i].delete();
    exp_q.delete();
    exp_out = 0;
    en = '0;
    drive_reqs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  // Monitor: every presented write must match the head of the expected queue
  always @(negedge clk) begin : mon
    addr_t e;
    if (reset_n && bus.tx_valid === 1'b1) begin
      tx_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL tx_extra: addr 0x%0h with nothing expected (cycle %0d)", bus.tx_addr, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("tx_addr", 64'(bus.tx_addr), 64'(e));
        chk("tx_data", 64'(bus.tx_data == line_data(e)), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ok_order;
    int c0, c1, c2, n_tx, n_blk;
    reset_n = 1'b0;
    drain_req = 1'b0;
    bus.tx_almfull = 1'b0;
    bus.wr_rsp_valid = 1'b0;
    en = '0;
    drive_reqs();
    @(posedge clk);
    #1;
    do_reset();

    // Single requester: five back-to-back lines
    clr_stats();
    for (int k = 0; k < 5; k++) begin
      src_q[0].push_back(addr_t'(42'h100 + k));
      exp_q.push_back(addr_t'(42'h100 + k));
    end
    en = 3'b001;
    drive_reqs();
    for (int t = 0; t < 20 && src_q[0].size() > 0; t++) tick();
    tick();
    chk("single_grants", 64'(n_g), 5);
    chk("single_span", 64'(g_last - g_first), 4);
    chk("single_outstanding", 64'(outstanding), 5);
    chk("single_tx_count", 64'(tx_cyc_q.size()), 5);
    if (tx_cyc_q.size() == 5) begin
      chk("single_latency", 64'(tx_cyc_q[0] - g_first), 1);
      chk("single_tx_span", 64'(tx_cyc_q[4] - tx_cyc_q[0]), 4);
    end
    ret_credits();

    // Fairness: all requesters valid, pointer freshly reset
    do_reset();
    clr_stats();
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < N_REQ; i++) begin
        src_q[i].push_back(addr_t'(42'h2000 + i * 16'h100 + k));
        exp_q.push_back(addr_t'(42'h2000 + i * 16'h100 + k));
      end
    en = 3'b111;
    drive_reqs();
    for (int t = 0; t < 40 && gnt_hist.size() < 30; t++) tick();
    ok_order = 1; c0 = 0; c1 = 0; c2 = 0;
    for (int j = 0; j < gnt_hist.size(); j++) begin
      if (gnt_hist[j] != j % 3) ok_order = 0;
      if (gnt_hist[j] == 0) c0++;
      if (gnt_hist[j] == 1) c1++;
      if (gnt_hist[j] == 2) c2++;
    end
    chk("fair_order", 64'(ok_order), 1);
    chk("fair_cnt0", 64'(c0), 10);
    chk("fair_cnt1", 64'(c1), 10);
    chk("fair_cnt2", 64'(c2), 10);
    chk("fair_span", 64'(g_last - g_first), 29);
    chk("fair_outstanding", 64'(outstanding), 30);
    ret_credits();

    // Backpressure: almfull high for 8 cycles with traffic on requester 0
    clr_stats();
    for (int k = 0; k < 20; k++) begin
      src_q[0].push_back(addr_t'(42'h3000 + k));
      exp_q.push_back(addr_t'(42'h3000 + k));
    end
    en = 3'b001;
    drive_reqs();
    for (int t = 0; t < 3; t++) tick();
    bus.tx_almfull = 1'b1;
    n_tx = 0; n_blk = 0;
    for (int w = 0; w < 8; w++) begin
      tick();
      n_tx += int'(txv_s);
      if (w == 0) chk("bp_grant_before_q", 64'(gs), 64'(3'b001));
      else if (gs != 0) n_blk++;
    end
    bus.tx_almfull = 1'b0;
    tick();
    n_tx += int'(txv_s);
    chk("bp_fall_cycle_nogrant", 64'(gs), 0);
    chk("bp_tx_after_rise", 64'(n_tx <= 2), 1);
    chk("bp_blocked_grants", 64'(n_blk), 0);
    tick();
    chk("bp_resume_grant", 64'(gs), 64'(3'b001));
    chk("bp_resume_no_tx_yet", 64'(txv_s), 0);
    tick();
    chk("bp_resume_tx", 64'(txv_s), 1);
    for (int t = 0; t < 40 && src_q[0].size() > 0; t++) tick();
    tick();
    ret_credits();

    // Credit limit: no responses until 32 writes are outstanding
    clr_stats();
    for (int k = 0; k < 40; k++) src_q[1].push_back(addr_t'(42'h4000 + k));
    for (int k = 0; k < 33; k++) exp_q.push_back(addr_t'(42'h4000 + k));
    en = 3'b010;
    drive_reqs();
    for (int t = 0; t < 36; t++) tick();
    chk("cl_grants", 64'(n_g), 32);
    chk("cl_outstanding_full", 64'(outstanding), 32);
    bus.wr_rsp_valid = 1'b1;
    tick();
    chk("cl_rsp_cycle_nogrant", 64'(gs), 0);
    bus.wr_rsp_valid = 1'b0;
    tick();
    chk("cl_extra_grant", 64'(gs), 64'(3'b010));
    tick();
    chk("cl_after_extra_nogrant", 64'(gs), 0);
    chk("cl_outstanding_back", 64'(outstanding), 32);
    src_q[1].delete();
    tick();
    ret_credits();

    // Drain: ten writes in flight, drain asserted in the cycle of the tenth grant
    clr_stats();
    for (int k = 0; k < 15; k++) begin
      src_q[2].push_back(addr_t'(42'h5000 + k));
      exp_q.push_back(addr_t'(42'h5000 + k));
    end
    en = 3'b100;
    drive_reqs();
    for (int t = 0; t < 20 && n_g < 9; t++) tick();
    drain_req = 1'b1;
    tick();
    chk("drain_grant_completes", 64'(gs), 64'(3'b100));
    n_blk = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (gs != 0) n_blk++;
    end
    chk("drain_no_grants", 64'(n_blk), 0);
    chk("drain_outstanding", 64'(outstanding), 10);
    chk("drain_done_busy", 64'(drain_done), 0);
    bus.wr_rsp_valid = 1'b1;
    for (int r = 0; r < 10; r++) tick();
    bus.wr_rsp_valid = 1'b0;
    chk("drain_done_early", 64'(drain_done), 0);
    tick();
    chk("drain_done_rise", 64'(drain_done), 1);
    tick();
    chk("drain_done_hold", 64'(drain_done), 1);
    chk("drain_done_nogrant", 64'(gs), 0);
    drain_req = 1'b0;
    tick();
    chk("drain_done_drop", 64'(drain_done), 0);
    tick();
    chk("drain_resume", 64'(gs), 64'(3'b100));
    for (int t = 0; t < 20 && src_q[2].size() > 0; t++) tick();
    tick();
    ret_credits();

    // Underflow: response with nothing outstanding
    bus.wr_rsp_valid = 1'b1;
    tick();
    bus.wr_rsp_valid = 1'b0;
    chk("underflow_set", 64'(rsp_underflow), 1);
    chk("underflow_cnt_zero", 64'(outstanding), 0);
    tick();
    chk("underflow_sticky", 64'(rsp_underflow), 1);

    // Asynchronous reset in the middle of a burst
    clr_stats();
    for (int k = 0; k < 10; k++) begin
      src_q[0].push_back(addr_t'(42'h6000 + k));
      exp_q.push_back(addr_t'(42'h6000 + k));
    end
    en = 3'b001;
    drive_reqs();
    for (int t = 0; t < 4; t++) tick();
    do_reset();
    for (int t = 0; t < 3; t++) tick();
    chk("post_reset_outstanding", 64'(outstanding), 0);
    chk("post_reset_tx_valid", 64'(bus.tx_valid), 0);
    chk("exp_queue_empty", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/qa_drv_hc_wr_sched.md
# qa_drv_hc_wr_sched

Round-robin scheduler that shares the CCI write request channel (c1 Tx) among the host-channel driver's write requesters: FIFO-to-host data, frame writer and status-manager updates. It sits between those requesters and the driver root's registered c1 Tx stage. It enforces almost-full backpressure and an outstanding-write credit limit, and provides a drain sequence so software can quiesce writes before a mode change.

## Interface
- N_REQ, 3, number of requesters; index 0 is FIFO-to-host, 1 is frame writer, 2 is status manager.
- MAX_OUTSTANDING, 32, maximum issued-but-unacknowledged writes; power of two, at most 256.
- ADDR_W, 42, cache-line address width.
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  N_REQ×ADDR_W  per-requester line address.
- req_data  in  N_REQ×512  per-requester line data.
- req_grant  out  N_REQ  one-hot grant; the requester consumes its request in the cycle the grant is high.
- tx_valid  out  1  registered write request to c1 Tx.
- tx_addr  out  ADDR_W  registered address.
- tx_data  out  512  registered data.
- tx_almfull  in  1  c1TxAlmFull from the FIU.
- wr_rsp_valid  in  1  one write response (c1 Rx) this cycle.
- drain_req  in  1  level-sensitive request to quiesce writes.
- drain_done  out  1  high when drained.
- outstanding  out  log2(MAX_OUTSTANDING)+1  current credit usage.
- rsp_underflow  out  1  sticky error flag.

## Operation
- States: RUN, DRAIN, DONE. Reset state is RUN.
  - RUN to DRAIN when drain_req=1.
  - DRAIN to DONE when outstanding==0 and tx_valid==0.
  - DRAIN or DONE to RUN when drain_req=0.
- Grants are legal only in RUN, with almfull_q==0 and outstanding < MAX_OUTSTANDING. almfull_q is tx_almfull registered one cycle.
- Round-robin arbitration:
  - Pointer last holds the index of the last granted requester. Search order is last+1, last+2, … modulo N_REQ.
  - At most one grant per cycle. last updates only on a grant.
- On a grant to requester i: tx_valid, tx_addr and tx_data load req_valid, req_addr[i] and req_data[i] on the next edge. With no grant, tx_valid loads 0 and tx_addr/tx_data hold.
- Credit counter:
  - +1 on each grant.
  - −1 on wr_rsp_valid.
  - Both in the same cycle: unchanged.
- Underflow: wr_rsp_valid with outstanding==0 leaves the counter at 0 and sets rsp_underflow. rsp_underflow clears only on reset.
- drain_done = (state==DONE), registered.
- Reset values: req_grant 0, tx_valid 0, tx_addr 0, tx_data 0, outstanding 0, rsp_underflow 0, drain_done 0, last N_REQ−1 (requester 0 wins first), almfull_q 1.
- Reset asserted mid-operation: all state returns to reset values immediately, and in-flight credits are discarded. After any reset, the driver root resets the FIU-side pipeline as well.

## Timing
- req_grant is combinational from registered state and req_valid. It has no combinational path from tx_almfull or wr_rsp_valid.
- Grant to tx_valid latency is 1 cycle. Sustained throughput is one write per cycle.
- Almost-full reaction:
  - tx_almfull rising at edge t blocks grants from cycle t+1 onward.
  - At most 2 writes appear on tx after almfull rises: one grant made in the cycle before almfull_q updates, plus the one already registered. The FIU tolerates this slack.
- Credit limit: outstanding reflects a grant on the next edge. A grant is never issued when outstanding==MAX_OUTSTANDING, even if a response arrives in the same cycle. That response frees the slot for the following cycle.
- drain_req asserted in the cycle of a grant: that grant completes. No further grants follow from the next cycle.
- drain_done rises at least one cycle after the last response.
- Deasserting drain_req drops drain_done the next cycle, and grants resume the cycle after.

## Test plan
- Single requester: req_valid=3'b001 with 5 back-to-back lines. Expect 5 consecutive tx_valid cycles starting 1 cycle after the first grant, with addresses in order and outstanding counting 1..5.
- Fairness: all three requesters valid continuously. Grants must follow 0,1,2,0,1,2… for 30 cycles, with exactly 10 grants per requester.
- Backpressure: pulse tx_almfull high for 8 cycles with traffic active. Expect no more than 2 tx_valid after the rise, none while almfull_q=1, and resumption 2 cycles after the fall.
- Credit limit: MAX_OUTSTANDING=32 with no responses. Grants stop at outstanding=32. One wr_rsp_valid gives exactly one more grant the next cycle, and outstanding stays at 32.
- Drain: 10 writes in flight, assert drain_req. No new grants, and drain_done=1 exactly 1 cycle after the 10th response. Deassert drain_req: drain_done=0 the next cycle, grants resume.
- Error and reset:
  - wr_rsp_valid at outstanding=0 sets rsp_underflow, and the counter stays 0.
  - reset_n asserted asynchronously mid-burst clears all outputs immediately, including rsp_underflow.
